mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage access sequencer, directly downstream of the region decoder.
//  - Consumes the decoded effective address plus one-hot region enables (tv, rv, txt, glb, stk, io).
//  - Drives byte-lane RAM writes and synchronous reads, and a valid/ready IO bus.
//  - Aligns and extends load data; stalls the pipeline while an access is outstanding.
//  - Raises faults for misaligned, unmapped, read-only-write and IO-timeout accesses.
// PARAMETERS
//  DATA_W      32  data bus width (fixed at 32; byte lanes = 4)
//  ADDR_W      32  effective address width
//  IO_TIMEOUT  16  max cycles o_io_valid may wait for i_io_ready before fault
// PORTS
//  i_clk          in   1       clock, rising edge
//  i_rst          in   1       synchronous, active-high reset
//  i_req_m        in   1       MEM-stage load/store request
//  i_we_m         in   1       1=store, 0=load
//  i_size_m       in   2       00 byte, 01 half, 10 word, 11 illegal
//  i_unsigned_m   in   1       load zero-extend (1) / sign-extend (0)
//  i_addr_eff_m   in   ADDR_W  region-relative effective address
//  i_wdata_m      in   DATA_W  store data, right-aligned
//  i_tv_en..i_io_en in 1 each  region enables (tv, rv, txt, glb, stk, io)
//  o_ram_sel      out  5       one-hot bank select {stk,glb,txt,rv,tv}
//  o_ram_en       out  1       RAM access strobe
//  o_ram_we       out  4       RAM byte write enables
//  o_ram_addr     out  ADDR_W  word address = {addr[31:2],2'b00}
//  o_ram_wdata    out  DATA_W  lane-replicated store data
//  i_ram_rdata    in   DATA_W  RAM read data, valid 1 cycle after o_ram_en
//  o_io_valid     out  1       IO request valid
//  o_io_we        out  1       IO write
//  o_io_be        out  4       IO byte enables
//  o_io_addr      out  ADDR_W  IO address (word aligned)
//  o_io_wdata     out  DATA_W  IO write data (lane-replicated)
//  i_io_ready     in   1       IO accept/complete
//  i_io_rdata     in   DATA_W  IO read data, valid with i_io_ready
//  o_stall_m      out  1       hold upstream pipeline
//  o_rdata        out  DATA_W  aligned/extended load result
//  o_rdata_valid  out  1       1-cycle pulse, o_rdata valid
//  o_fault        out  1       1-cycle fault pulse
//  o_fault_cause  out  3       1 misaligned, 2 unmapped, 3 RO write, 4 IO timeout, 5 illegal size
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; timeout counter 0. Reset mid-IO drops o_io_valid next edge, no rdata/fault.
//  - FSM: IDLE, RAM_RD, IO_WAIT, RESP.
//  - Request acceptance: only in IDLE with i_req_m=1. i_req_m is ignored in all other states (upstream holds while stalled).
//  - Check priority at acceptance: illegal size > misaligned (half addr[0]!=0, word addr[1:0]!=0) > unmapped (enables not exactly one-hot) > store to tv/rv/txt.
//    On fault: o_fault=1 and cause in the next cycle, no RAM/IO strobe, no stall, stay IDLE.
//  - Byte lanes: byte be=4'b0001<<addr[1:0]; half be=4'b0011<<{addr[1],1'b0}; word be=4'b1111.
//    wdata replicated: byte x4, half x2.
//  - RAM store: combinational o_ram_en/o_ram_we/o_ram_sel in the acceptance cycle; zero stall; stay IDLE.
//  - RAM load: o_ram_en=1, o_ram_we=0 at T; o_stall_m=1 at T and T+1 (RAM_RD).
//    i_ram_rdata captured at end of T+1, lane-shifted and extended; RESP at T+2 drives o_rdata_valid=1, o_stall_m=0.
//  - IO access: o_stall_m=1 from T. o_io_* registered, valid from T+1, held stable until ready or timeout.
//    i_io_ready sampled only while o_io_valid=1; on the ready cycle o_io_valid drops next edge.
//    Load data captured; RESP pulses o_rdata_valid. IO store: no rdata_valid, stall releases the cycle after ready.
//  - Timeout: counter counts o_io_valid cycles. At IO_TIMEOUT with no ready, drop valid and pulse fault cause 4; i_io_ready in that same cycle wins (no fault).
//  - RESP always returns to IDLE; a new request may be accepted in the cycle after RESP.
// TESTING
//  - glb store word 0xDEADBEEF @0x10 -> o_ram_we=1111, o_ram_sel=5'b01000, no stall, no fault.
//  - stk load byte signed @0x3, rdata 0x80xxxxxx -> stall 2 cycles, o_rdata=0xFFFFFF80 valid at T+2; unsigned -> 0x00000080.
//  - txt store / half @0x1 / size 11 / no enable -> fault causes 3 / 1 / 5 / 2, no RAM/IO strobe.
//  - io load @0x10, ready after 3 cycles, rdata 0x1234 -> valid held 3 cycles, o_rdata=0x00001234, stall released on RESP.
//  - io store, ready never asserted -> valid for 16 cycles then drops, fault cause 4; ready on cycle 16 -> no fault.
//  - i_rst asserted during IO_WAIT -> o_io_valid=0, o_stall_m=0 next cycle, no rdata_valid/fault.

Source files
------------

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage access sequencer placed directly after the region decoder.
// Takes a region-relative effective address plus one-hot region enables and
// turns each load/store into one of:
//   - a single-cycle RAM store (byte-lane write enables, no stall),
//   - a RAM load (synchronous read, 2-cycle stall, result pulse at T+2),
//   - an IO bus transaction (registered valid/ready handshake with timeout),
//   - a fault pulse (illegal size, misaligned, unmapped, read-only write).
//
// Ports
//   i_clk, i_rst          clock (rising edge), synchronous active-high reset
//   i_req_m .. i_wdata_m  MEM-stage request: store flag, size, load extension,
//                         effective address, right-aligned store data
//   i_*_en                region enables {io, stk, glb, txt, rv, tv}
//   o_ram_*               RAM bank select, strobe, byte enables, word
//                         address, lane-replicated store data
//   i_ram_rdata           RAM read data, valid one cycle after o_ram_en
//   o_io_* / i_io_*       IO request channel (valid/ready) and read data
//   o_stall_m             holds the upstream pipeline
//   o_rdata, o_rdata_valid  aligned/extended load result and its pulse
//   o_fault, o_fault_cause  fault pulse and cause code
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int IO_TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_m,
    input  logic              i_we_m,
    input  logic [1:0]        i_size_m,
    input  logic              i_unsigned_m,
    input  logic [ADDR_W-1:0] i_addr_eff_m,
    input  logic [DATA_W-1:0] i_wdata_m,
    input  logic              i_tv_en,
    input  logic              i_rv_en,
    input  logic              i_txt_en,
    input  logic              i_glb_en,
    input  logic              i_stk_en,
    input  logic              i_io_en,
    output logic [4:0]        o_ram_sel,
    output logic              o_ram_en,
    output logic [3:0]        o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic              o_io_valid,
    output logic              o_io_we,
    output logic [3:0]        o_io_be,
    output logic [ADDR_W-1:0] o_io_addr,
    output logic [DATA_W-1:0] o_io_wdata,
    input  logic              i_io_ready,
    input  logic [DATA_W-1:0] i_io_rdata,
    output logic              o_stall_m,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rdata_valid,
    output logic              o_fault,
    output logic [2:0]        o_fault_cause
);

    localparam int CNT_W = $clog2(IO_TIMEOUT + 1);

    localparam logic [2:0] CAUSE_NONE     = 3'd0;
    localparam logic [2:0] CAUSE_MISALIGN = 3'd1;
    localparam logic [2:0] CAUSE_UNMAPPED = 3'd2;
    localparam logic [2:0] CAUSE_RO_WRITE = 3'd3;
    localparam logic [2:0] CAUSE_IO_TMO   = 3'd4;
    localparam logic [2:0] CAUSE_SIZE     = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RAM_RD,
        S_IO_WAIT,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Request classification
    logic [5:0]        w_en_vec;
    logic              w_onehot;
    logic              w_misaligned;
    logic [2:0]        w_cause;
    logic              w_accept;
    logic              w_fault_det;
    logic              w_ram_go;
    logic              w_io_go;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata_rep;
    logic [ADDR_W-1:0] w_word_addr;

    // IO completion / timeout in the current cycle
    logic              w_io_done;
    logic              w_io_tmo;

    // Registered state
    logic [1:0]        r_size;
    logic [1:0]        r_lane;
    logic              r_unsigned;
    logic              r_io_valid;
    logic              r_io_we;
    logic [3:0]        r_io_be;
    logic [ADDR_W-1:0] r_io_addr;
    logic [DATA_W-1:0] r_io_wdata;
    logic [CNT_W-1:0]  r_tmo_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic              r_fault;
    logic [2:0]        r_fault_cause;

    // Shift the addressed lane down to bit 0, then zero- or sign-extend.
    function automatic logic [DATA_W-1:0] f_align(
        input logic [DATA_W-1:0] d,
        input logic [1:0]        size,
        input logic [1:0]        lane,
        input logic              uns
    );
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] res;
        sh = d >> {lane, 3'b000};
        case (size)
            2'b00:   res = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   res = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    assign w_en_vec     = {i_io_en, i_stk_en, i_glb_en, i_txt_en, i_rv_en, i_tv_en};
    assign w_onehot     = (w_en_vec != 6'd0) && ((w_en_vec & (w_en_vec - 6'd1)) == 6'd0);
    assign w_misaligned = ((i_size_m == 2'b01) && i_addr_eff_m[0]) ||
                          ((i_size_m == 2'b10) && (i_addr_eff_m[1:0] != 2'b00));
    assign w_word_addr  = {i_addr_eff_m[ADDR_W-1:2], 2'b00};

    // Fault checks in priority order; the first match wins.
    always_comb begin
        w_cause = CAUSE_NONE;
        if (i_size_m == 2'b11) begin
            w_cause = CAUSE_SIZE;
        end else if (w_misaligned) begin
            w_cause = CAUSE_MISALIGN;
        end else if (!w_onehot) begin
            w_cause = CAUSE_UNMAPPED;
        end else if (i_we_m && (i_tv_en || i_rv_en || i_txt_en)) begin
            w_cause = CAUSE_RO_WRITE;
        end
    end

    // Reset is folded in so the combinational strobes stay low while i_rst is high.
    assign w_accept    = (r_state == S_IDLE) && i_req_m && !i_rst;
    assign w_fault_det = w_accept && (w_cause != CAUSE_NONE);
    // With no fault the enables are one-hot, so i_io_en alone picks the path.
    assign w_ram_go    = w_accept && (w_cause == CAUSE_NONE) && !i_io_en;
    assign w_io_go     = w_accept && (w_cause == CAUSE_NONE) && i_io_en;

    always_comb begin
        case (i_size_m)
            2'b00:   w_be = 4'b0001 << i_addr_eff_m[1:0];
            2'b01:   w_be = 4'b0011 << {i_addr_eff_m[1], 1'b0};
            default: w_be = 4'b1111;
        endcase
    end

    always_comb begin
        case (i_size_m)
            2'b00:   w_wdata_rep = {4{i_wdata_m[7:0]}};
            2'b01:   w_wdata_rep = {2{i_wdata_m[15:0]}};
            default: w_wdata_rep = i_wdata_m;
        endcase
    end

    // The counter holds (number of valid cycles so far - 1); ready on the
    // last allowed cycle takes precedence over the timeout.
    assign w_io_done = (r_state == S_IO_WAIT) && i_io_ready;
    assign w_io_tmo  = (r_state == S_IO_WAIT) && !i_io_ready &&
                       (r_tmo_cnt == CNT_W'(IO_TIMEOUT - 1));

    // State register
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and combinational RAM/stall outputs
    always_comb begin
        // NOTE: all outputs of this block are defaulted up front so no
        // branch can leave one unassigned and infer a latch.
        w_next_state = r_state;
        o_ram_en     = 1'b0;
        o_ram_we     = 4'b0000;
        o_ram_sel    = 5'b00000;
        o_ram_addr   = '0;
        o_ram_wdata  = '0;
        o_stall_m    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_ram_go) begin
                    o_ram_en   = 1'b1;
                    o_ram_sel  = w_en_vec[4:0];
                    o_ram_addr = w_word_addr;
                    if (i_we_m) begin
                        o_ram_we    = w_be;
                        o_ram_wdata = w_wdata_rep;
                    end else begin
                        o_stall_m    = 1'b1;
                        w_next_state = S_RAM_RD;
                    end
                end else if (w_io_go) begin
                    o_stall_m    = 1'b1;
                    w_next_state = S_IO_WAIT;
                end
            end
            S_RAM_RD: begin
                o_stall_m    = 1'b1;
                w_next_state = S_RESP;
            end
            S_IO_WAIT: begin
                o_stall_m = 1'b1;
                if (w_io_done) begin
                    // Stores have no result to return and release at once.
                    w_next_state = r_io_we ? S_IDLE : S_RESP;
                end else if (w_io_tmo) begin
                    w_next_state = S_IDLE;
                end
            end
            S_RESP: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath registers: request context, IO channel, timeout, result, fault
    always_ff @(posedge i_clk) begin
        // NOTE: every register here is reset, including the data holders,
        // because all outputs must read zero straight out of reset.
        if (i_rst) begin
            r_size        <= 2'b00;
            r_lane        <= 2'b00;
            r_unsigned    <= 1'b0;
            r_io_valid    <= 1'b0;
            r_io_we       <= 1'b0;
            r_io_be       <= 4'b0000;
            r_io_addr     <= '0;
            r_io_wdata    <= '0;
            r_tmo_cnt     <= '0;
            r_rdata       <= '0;
            r_fault       <= 1'b0;
            r_fault_cause <= CAUSE_NONE;
        end else begin
            r_fault       <= w_fault_det || w_io_tmo;
            r_fault_cause <= w_fault_det ? w_cause :
                             (w_io_tmo ? CAUSE_IO_TMO : CAUSE_NONE);

            if (w_ram_go || w_io_go) begin
                r_size     <= i_size_m;
                r_lane     <= i_addr_eff_m[1:0];
                r_unsigned <= i_unsigned_m;
            end

            if (w_io_go) begin
                r_io_valid <= 1'b1;
                r_io_we    <= i_we_m;
                r_io_be    <= w_be;
                r_io_addr  <= w_word_addr;
                r_io_wdata <= i_we_m ? w_wdata_rep : '0;
                r_tmo_cnt  <= '0;
            end else if (w_io_done || w_io_tmo) begin
                r_io_valid <= 1'b0;
                r_io_we    <= 1'b0;
                r_io_be    <= 4'b0000;
                r_io_addr  <= '0;
                r_io_wdata <= '0;
                r_tmo_cnt  <= '0;
            end else if (r_state == S_IO_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
            end

            if (r_state == S_RAM_RD) begin
                r_rdata <= f_align(i_ram_rdata, r_size, r_lane, r_unsigned);
            end else if (w_io_done && !r_io_we) begin
                r_rdata <= f_align(i_io_rdata, r_size, r_lane, r_unsigned);
            end
        end
    end

    assign o_io_valid    = r_io_valid;
    assign o_io_we       = r_io_we;
    assign o_io_be       = r_io_be;
    assign o_io_addr     = r_io_addr;
    assign o_io_wdata    = r_io_wdata;
    assign o_rdata       = r_rdata;
    assign o_rdata_valid = (r_state == S_RESP);
    assign o_fault       = r_fault;
    assign o_fault_cause = r_fault_cause;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Self-checking bench for mem_access_unit. Each transaction is predicted from
// the access rules (fault priority, byte lanes, replication, load extension,
// stall/response timing) using plain arithmetic, then the DUT is observed
// cycle by cycle. Directed cases come first, then randomized traffic.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int IO_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [5:0]  en = '0;      // {io, stk, glb, txt, rv, tv}
    logic [31:0] ram_rdata = '0;
    logic        io_ready = 1'b0;
    logic [31:0] io_rdata = '0;

    logic [4:0]  o_ram_sel;
    logic        o_ram_en;
    logic [3:0]  o_ram_we;
    logic [31:0] o_ram_addr;
    logic [31:0] o_ram_wdata;
    logic        o_io_valid;
    logic        o_io_we;
    logic [3:0]  o_io_be;
    logic [31:0] o_io_addr;
    logic [31:0] o_io_wdata;
    logic        o_stall_m;
    logic [31:0] o_rdata;
    logic        o_rdata_valid;
    logic        o_fault;
    logic [2:0]  o_fault_cause;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_unit #(
        .DATA_W     (32),
        .ADDR_W     (32),
        .IO_TIMEOUT (IO_TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_m       (req),
        .i_we_m        (we),
        .i_size_m      (size),
        .i_unsigned_m  (uns),
        .i_addr_eff_m  (addr),
        .i_wdata_m     (wdata),
        .i_tv_en       (en[0]),
        .i_rv_en       (en[1]),
        .i_txt_en      (en[2]),
        .i_glb_en      (en[3]),
        .i_stk_en      (en[4]),
        .i_io_en       (en[5]),
        .o_ram_sel     (o_ram_sel),
        .o_ram_en      (o_ram_en),
        .o_ram_we      (o_ram_we),
        .o_ram_addr    (o_ram_addr),
        .o_ram_wdata   (o_ram_wdata),
        .i_ram_rdata   (ram_rdata),
        .o_io_valid    (o_io_valid),
        .o_io_we       (o_io_we),
        .o_io_be       (o_io_be),
        .o_io_addr     (o_io_addr),
        .o_io_wdata    (o_io_wdata),
        .i_io_ready    (io_ready),
        .i_io_rdata    (io_rdata),
        .o_stall_m     (o_stall_m),
        .o_rdata       (o_rdata),
        .o_rdata_valid (o_rdata_valid),
        .o_fault       (o_fault),
        .o_fault_cause (o_fault_cause)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int model_cause(input logic t_we, input logic [1:0] t_size,
                                       input logic [31:0] t_addr, input logic [5:0] t_en);
        int unsigned off;
        off = t_addr % 4;
        if (t_size == 2'd3) return 5;
        if ((t_size == 2'd1 && (off % 2) != 0) || (t_size == 2'd2 && off != 0)) return 1;
        if ($countones(t_en) != 1) return 2;
        if (t_we && (t_en[0] || t_en[1] || t_en[2])) return 3;
        return 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] t_size, input logic [31:0] t_addr);
        int unsigned off;
        off = t_addr % 4;
        if (t_size == 2'd0) return 4'(1 << off);
        if (t_size == 2'd1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_rep(input logic [1:0] t_size, input logic [31:0] d);
        if (t_size == 2'd0) return (d % 256) * 32'h0101_0101;
        if (t_size == 2'd1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] t_size, input logic t_uns,
                                               input logic [31:0] t_addr, input logic [31:0] d);
        int unsigned nbits;
        logic [31:0] v;
        logic [31:0] mask;
        if (t_size == 2'd2) return d;
        nbits = (t_size == 2'd0) ? 8 : 16;
        mask  = (32'd1 << nbits) - 32'd1;
        v     = (d >> (8 * (t_addr % 4))) & mask;
        if (!t_uns && v >= (32'd1 << (nbits - 1))) v = v | ~mask;
        return v;
    endfunction

    // ---------------- one transaction ----------------
    // ready_at: valid cycle (1-based) on which i_io_ready is raised; any value
    // outside 1..IO_TIMEOUT means the IO side never answers.
    task automatic run_txn(input logic t_we, input logic [1:0] t_size, input logic t_uns,
                           input logic [31:0] t_addr, input logic [31:0] t_wdata,
                           input logic [5:0] t_en, input int ready_at, input logic [31:0] t_rd);
        int          cause;
        logic [3:0]  be;
        logic [31:0] rep;
        logic [31:0] ld;
        bit          answered;
        cause    = model_cause(t_we, t_size, t_addr, t_en);
        be       = model_be(t_size, t_addr);
        rep      = model_rep(t_size, t_wdata);
        ld       = model_load(t_size, t_uns, t_addr, t_rd);
        answered = (ready_at >= 1 && ready_at <= IO_TIMEOUT);

        next_cycle();
        req = 1'b1; we = t_we; size = t_size; uns = t_uns;
        addr = t_addr; wdata = t_wdata; en = t_en;
        ram_rdata = $urandom;
        io_ready  = 1'($urandom % 2);   // ignored while o_io_valid is low
        @(negedge clk);
        check("idle_fault", 32'(o_fault), 32'd0);
        check("idle_rvalid", 32'(o_rdata_valid), 32'd0);
        check("idle_io_valid", 32'(o_io_valid), 32'd0);

        if (cause != 0) begin
            check("flt_ram_en", 32'(o_ram_en), 32'd0);
            check("flt_stall", 32'(o_stall_m), 32'd0);
            next_cycle();
            req = 1'b0; io_ready = 1'b0;
            @(negedge clk);
            check("flt_pulse", 32'(o_fault), 32'd1);
            check("flt_cause", 32'(o_fault_cause), 32'(cause));
            check("flt_io_valid", 32'(o_io_valid), 32'd0);
            check("flt_stall_t1", 32'(o_stall_m), 32'd0);
        end else if (!t_en[5]) begin
            check("ram_en", 32'(o_ram_en), 32'd1);
            check("ram_we", 32'(o_ram_we), t_we ? 32'(be) : 32'd0);
            check("ram_sel", 32'(o_ram_sel), 32'(t_en[4:0]));
            check("ram_addr", o_ram_addr, t_addr - (t_addr % 4));
            check("ram_stall_t0", 32'(o_stall_m), t_we ? 32'd0 : 32'd1);
            if (t_we) check("ram_wdata", o_ram_wdata, rep);
            next_cycle();
            req = 1'b0; io_ready = 1'b0;
            if (t_we) begin
                @(negedge clk);
                check("st_stall_t1", 32'(o_stall_m), 32'd0);
                check("st_fault_t1", 32'(o_fault), 32'd0);
                check("st_ram_en_t1", 32'(o_ram_en), 32'd0);
            end else begin
                ram_rdata = t_rd;
                @(negedge clk);
                check("ld_stall_t1", 32'(o_stall_m), 32'd1);
                check("ld_rvalid_t1", 32'(o_rdata_valid), 32'd0);
                check("ld_ram_en_t1", 32'(o_ram_en), 32'd0);
                next_cycle();
                ram_rdata = $urandom;
                @(negedge clk);
                check("ld_rvalid_t2", 32'(o_rdata_valid), 32'd1);
                check("ld_rdata_t2", o_rdata, ld);
                check("ld_stall_t2", 32'(o_stall_m), 32'd0);
            end
        end else begin
            check("io_stall_t0", 32'(o_stall_m), 32'd1);
            check("io_ram_en_t0", 32'(o_ram_en), 32'd0);
            next_cycle();
            req = 1'b0; io_ready = 1'b0;
            for (int k = 1; k <= IO_TIMEOUT; k++) begin
                if (k == ready_at) begin
                    io_ready = 1'b1;
                    io_rdata = t_rd;
                end
                @(negedge clk);
                check("io_valid", 32'(o_io_valid), 32'd1);
                check("io_stall", 32'(o_stall_m), 32'd1);
                check("io_addr", o_io_addr, t_addr - (t_addr % 4));
                check("io_be", 32'(o_io_be), 32'(be));
                check("io_we", 32'(o_io_we), 32'(t_we));
                if (t_we) check("io_wdata", o_io_wdata, rep);
                next_cycle();
                io_ready = 1'b0;
                io_rdata = $urandom;
                if (k == ready_at) break;
            end
            @(negedge clk);
            check("io_valid_end", 32'(o_io_valid), 32'd0);
            check("io_stall_end", 32'(o_stall_m), 32'd0);
            if (answered) begin
                check("io_fault_none", 32'(o_fault), 32'd0);
                check("io_rvalid", 32'(o_rdata_valid), t_we ? 32'd0 : 32'd1);
                if (!t_we) check("io_rdata", o_rdata, ld);
            end else begin
                check("io_tmo_fault", 32'(o_fault), 32'd1);
                check("io_tmo_cause", 32'(o_fault_cause), 32'd4);
                check("io_tmo_rvalid", 32'(o_rdata_valid), 32'd0);
            end
        end
    endtask

    // Reset asserted while an IO load is waiting; ready arrives in the reset
    // cycle and must be discarded.
    task automatic reset_mid_io();
        next_cycle();
        req = 1'b1; we = 1'b0; size = 2'd2; uns = 1'b0;
        addr = 32'h20; wdata = '0; en = 6'b100000;
        next_cycle();
        req = 1'b0;
        next_cycle();
        @(negedge clk);
        check("rst_io_pre_valid", 32'(o_io_valid), 32'd1);
        next_cycle();
        rst = 1'b1; io_ready = 1'b1; io_rdata = 32'hCAFE_F00D;
        next_cycle();
        rst = 1'b0; io_ready = 1'b0;
        @(negedge clk);
        check("rst_io_valid", 32'(o_io_valid), 32'd0);
        check("rst_stall", 32'(o_stall_m), 32'd0);
        check("rst_rvalid", 32'(o_rdata_valid), 32'd0);
        check("rst_fault", 32'(o_fault), 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        next_cycle();
        @(negedge clk);
        check("rst_rvalid_t2", 32'(o_rdata_valid), 32'd0);
        check("rst_fault_t2", 32'(o_fault), 32'd0);
    endtask

    function automatic logic [5:0] rand_en();
        int unsigned r;
        int unsigned a;
        int unsigned b;
        r = $urandom % 10;
        a = $urandom % 6;
        b = (a + 1 + ($urandom % 5)) % 6;
        if (r == 0) return 6'd0;
        if (r == 1) return 6'(1 << a) | 6'(1 << b);
        if (r <= 4) return 6'b100000;
        return 6'(1 << a);
    endfunction

    initial begin
        logic [1:0]  r_size_v;
        logic [31:0] r_addr_v;
        int unsigned r;

        rst = 1'b1;
        repeat (3) next_cycle();
        @(negedge clk);
        check("reset_ram_en", 32'(o_ram_en), 32'd0);
        check("reset_stall", 32'(o_stall_m), 32'd0);
        check("reset_io_valid", 32'(o_io_valid), 32'd0);
        check("reset_rvalid", 32'(o_rdata_valid), 32'd0);
        check("reset_fault", 32'(o_fault), 32'd0);
        check("reset_rdata", o_rdata, 32'd0);
        next_cycle();
        rst = 1'b0;

        // Directed cases
        run_txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 6'b001000, 0, 32'd0);
        run_txn(1'b0, 2'd0, 1'b0, 32'h3, 32'd0, 6'b010000, 0, 32'h8012_3456);
        run_txn(1'b0, 2'd0, 1'b1, 32'h3, 32'd0, 6'b010000, 0, 32'h8012_3456);
        run_txn(1'b1, 2'd2, 1'b0, 32'h0, 32'h1111_2222, 6'b000100, 0, 32'd0);
        run_txn(1'b0, 2'd1, 1'b0, 32'h1, 32'd0, 6'b001000, 0, 32'd0);
        run_txn(1'b0, 2'd3, 1'b0, 32'h0, 32'd0, 6'b001000, 0, 32'd0);
        run_txn(1'b0, 2'd2, 1'b0, 32'h0, 32'd0, 6'b000000, 0, 32'd0);
        run_txn(1'b1, 2'd1, 1'b0, 32'h6, 32'h0000_ABCD, 6'b010000, 0, 32'd0);
        run_txn(1'b1, 2'd0, 1'b0, 32'h5, 32'h0000_005A, 6'b001000, 0, 32'd0);
        run_txn(1'b0, 2'd1, 1'b0, 32'h2, 32'd0, 6'b001000, 0, 32'h8765_4321);
        run_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 6'b100000, 3, 32'h0000_1234);
        run_txn(1'b1, 2'd2, 1'b0, 32'h14, 32'h5555_AAAA, 6'b100000, 0, 32'd0);
        run_txn(1'b1, 2'd2, 1'b0, 32'h18, 32'h6666_BBBB, 6'b100000, IO_TIMEOUT, 32'd0);
        run_txn(1'b0, 2'd0, 1'b0, 32'h1, 32'd0, 6'b100000, 1, 32'h0000_F000);
        reset_mid_io();

        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            r = $urandom % 16;
            r_size_v = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
            r_addr_v = $urandom;
            if (($urandom % 8) != 0) begin
                if (r_size_v == 2'd1) r_addr_v = r_addr_v - (r_addr_v % 2);
                if (r_size_v == 2'd2) r_addr_v = r_addr_v - (r_addr_v % 4);
            end
            run_txn(1'($urandom % 2), r_size_v, 1'($urandom % 2), r_addr_v, $urandom,
                    rand_en(), int'($urandom_range(1, 20)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
